// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default port widths, dstreak counter width helper.
package mem_arb_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_DSTREAK = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  // Width able to hold 0..max_streak; never zero so the counter always exists.
  function automatic int streak_w(input int max_streak);
    return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the fetch and data requesters.
// Latency: purely combinational.
// Backpressure: grants only while arb_en (arbiter idle); a masked winner yields no grant.
// Ports:
//   arb_en         - arbitration allowed this cycle (FSM in IDLE)
//   i_req, d_req   - raw fetch / data requests
//   i_mask, d_mask - requester just completed (its valid pulse is high)
//   streak_full    - data has won MAX_DSTREAK times while a fetch waited
//   grant_i, grant_d - one-hot (or zero) grant
module mem_arb_pick (
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  input  logic i_mask,
  input  logic d_mask,
  input  logic streak_full,
  output logic grant_i,
  output logic grant_d
);

  logic win_i;
  logic win_d;

  always_comb begin
    // Priority is decided on the raw requests. If the winner is the requester
    // that is completing this cycle, nobody is granted: its held request must
    // not be served twice, and handing the slot to the loser instead would
    // silently bypass data priority and the streak limit.
    win_i   = i_req && (!d_req || streak_full);
    win_d   = d_req && !win_i;
    grant_i = arb_en && win_i && !i_mask;
    grant_d = arb_en && win_d && !d_mask;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one shared memory port.
// Latency: request sampled at edge t -> mem_req from t+1; valid one cycle after the acked edge.
// Backpressure: requesters wait (req held) until their valid pulse; memory stalls via mem_ack.
// Ports:
//   clk, reset (async, active low)
//   fetch: i_req, i_addr -> i_rdata, i_valid
//   data:  d_req, d_we, d_be, d_addr, d_wdata -> d_rdata, d_valid
//   memory: mem_req, mem_we, mem_be, mem_addr, mem_wdata <- mem_rdata, mem_ack
//   busy: high whenever the FSM is not IDLE
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_DSTREAK = DEF_MAX_DSTREAK
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_valid,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = streak_w(MAX_DSTREAK);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [SW-1:0]     dstreak_q;
  logic              streak_full;
  logic              grant_i;
  logic              grant_d;

  // Holding registers: the only source of the shared-port outputs, so the
  // port stays stable for the whole transaction regardless of requester inputs.
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  assign streak_full = (dstreak_q == SW'(MAX_DSTREAK));

  mem_arb_pick u_pick (
    .arb_en      (state_q == IDLE),
    .i_req       (i_req),
    .d_req       (d_req),
    .i_mask      (i_valid),
    .d_mask      (d_valid),
    .streak_full (streak_full),
    .grant_i     (grant_i),
    .grant_d     (grant_d)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d = state_q;
    mem_req = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d = SERVE_I;
        end else if (grant_d) begin
          state_d = SERVE_D;
        end
      end
      SERVE_I, SERVE_D: begin
        mem_req = 1'b1;
        busy    = 1'b1;
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture, completion and streak bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      dstreak_q <= '0;
      i_rdata   <= '0;
      i_valid   <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;

      if (grant_i) begin
        // Fetches are always full-word reads.
        addr_q  <= i_addr;
        we_q    <= 1'b0;
        be_q    <= '1;
        wdata_q <= '0;
      end else if (grant_d) begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        be_q    <= d_be;
        wdata_q <= d_wdata;
      end

      // Count only data wins that actually kept a fetch waiting.
      if (grant_i) begin
        dstreak_q <= '0;
      end else if (grant_d && i_req && !streak_full) begin
        dstreak_q <= dstreak_q + SW'(1);
      end

      if (state_q == SERVE_I && mem_ack) begin
        i_rdata <= mem_rdata;
        i_valid <= 1'b1;
      end

      if (state_q == SERVE_D && mem_ack) begin
        d_valid <= 1'b1;
        // Stores return nothing; keep the last load result visible.
        if (!we_q) begin
          d_rdata <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboarded memory transactions and read-back data.
// Latency: n/a (testbench).
// Backpressure: memory responder inserts a programmable number of wait cycles.
module tb_mem_arbiter;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  txn_t        mem_exp_q[$];
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  int          mem_wait = 0;
  bit          spurious = 1'b0;
  int          txn_cnt = 0;
  logic [31:0] last_load = 32'h0;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_valid   (i_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return {a[15:0], 16'h5A3C} ^ 32'h1234_0000;
  endfunction

  task automatic exp_fetch(input logic [31:0] a);
    txn_t t;
    t.addr = a; t.we = 1'b0; t.be = 4'hF; t.wdata = 32'h0;
    mem_exp_q.push_back(t);
    i_exp_q.push_back(mem_val(a));
  endtask

  task automatic exp_data(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input bit completes);
    txn_t t;
    t.addr = a; t.we = we; t.be = be; t.wdata = wd;
    mem_exp_q.push_back(t);
    if (completes) begin
      if (!we) last_load = mem_val(a);
      d_exp_q.push_back(last_load);
    end
  endtask

  task automatic wait_vld(input bit is_d, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(is_d ? d_valid : i_valid) && cycles < budget);
    chk(is_d ? "d_vld_seen" : "i_vld_seen", 128'(is_d ? d_valid : i_valid), 128'(1));
  endtask

  // Memory responder: checks each transaction against the scoreboard and its stability.
  initial begin
    bit   in_txn;
    int   wcnt;
    txn_t held;
    txn_t got;
    txn_t exp;
    in_txn    = 1'b0;
    wcnt      = 0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        in_txn  = 1'b0;
        mem_ack = spurious;
      end else begin
        got.addr = mem_addr; got.we = mem_we; got.be = mem_be; got.wdata = mem_wdata;
        if (!in_txn) begin
          in_txn = 1'b1;
          wcnt   = 0;
          held   = got;
          txn_cnt++;
          chk("mem_txn_expected", 128'(mem_exp_q.size() != 0), 128'(1));
          if (mem_exp_q.size() != 0) begin
            exp = mem_exp_q.pop_front();
            if (!exp.we) begin
              exp.wdata = 32'h0;
              got.wdata = 32'h0;
            end
            chk("mem_txn", 128'(got), 128'(exp));
          end
        end else begin
          chk("mem_stable", 128'(got), 128'(held));
        end
        if (wcnt == mem_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_val(mem_addr);
        end
        wcnt++;
      end
    end
  end

  // Completion monitor
  initial begin
    forever begin
      @(negedge clk);
      if (i_valid) begin
        chk("i_vld_expected", 128'(i_exp_q.size() != 0), 128'(1));
        if (i_exp_q.size() != 0) chk("i_rdata", 128'(i_rdata), 128'(i_exp_q.pop_front()));
      end
      if (d_valid) begin
        chk("d_vld_expected", 128'(d_exp_q.size() != 0), 128'(1));
        if (d_exp_q.size() != 0) chk("d_rdata", 128'(d_rdata), 128'(d_exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    bit i_done;
    reset = 1'b0; i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_i_valid", 128'(i_valid), 128'(0));
    chk("rst_d_valid", 128'(d_valid), 128'(0));
    chk("rst_i_rdata", 128'(i_rdata), 128'(0));
    chk("rst_d_rdata", 128'(d_rdata), 128'(0));
    chk("rst_mem_port", 128'({mem_addr, mem_we, mem_be, mem_wdata}), 128'(0));
    reset = 1'b1;

    // Lone fetch, ack after 3 wait cycles
    @(negedge clk);
    mem_wait = 3;
    exp_fetch(32'h100);
    i_req = 1'b1; i_addr = 32'h100;
    @(negedge clk);
    chk("s1_mem_req", 128'(mem_req), 128'(1));
    chk("s1_busy", 128'(busy), 128'(1));
    chk("s1_mem_addr", 128'(mem_addr), 128'(32'h100));
    chk("s1_mem_we", 128'(mem_we), 128'(0));
    wait_vld(1'b0, 20, n);
    i_req = 1'b0;
    @(negedge clk);
    chk("s1_pulse_end", 128'(i_valid), 128'(0));

    // Zero-wait load: completion two cycles after the request is driven
    @(negedge clk);
    mem_wait = 0;
    exp_data(32'h40, 1'b0, 4'hF, 32'h0, 1'b1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF; d_wdata = 32'h0;
    wait_vld(1'b1, 20, n);
    d_req = 1'b0;
    chk("s2_latency", 128'(n), 128'(2));

    // Simultaneous: data store first, then the fetch; d_rdata unchanged
    @(negedge clk);
    mem_wait = 1;
    exp_data(32'h2000, 1'b1, 4'h3, 32'hCAFE_F00D, 1'b1);
    exp_fetch(32'h104);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_be = 4'h3; d_wdata = 32'hCAFE_F00D;
    i_req = 1'b1; i_addr = 32'h104;
    @(negedge clk);
    chk("s3_mem_be", 128'(mem_be), 128'(4'h3));
    chk("s3_mem_we", 128'(mem_we), 128'(1));
    wait_vld(1'b1, 20, n);
    d_req = 1'b0; d_we = 1'b0;
    wait_vld(1'b0, 20, n);
    i_req = 1'b0;

    // Held request through d_valid: only one transaction
    @(negedge clk);
    mem_wait = 0;
    k = txn_cnt;
    exp_data(32'h300, 1'b0, 4'hF, 32'h0, 1'b1);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
    wait_vld(1'b1, 20, n);
    @(negedge clk);
    chk("s4_no_regrant", 128'(busy), 128'(0));
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("s4_txn_count", 128'(txn_cnt - k), 128'(1));

    // Starvation limit: fetch wins right after the 4th data grant
    @(negedge clk);
    mem_wait = 0;
    for (int j = 0; j < 4; j++) exp_data(32'h1000 + 32'(4 * j), 1'b0, 4'hF, 32'h0, 1'b1);
    exp_fetch(32'h200);
    exp_data(32'h1010, 1'b0, 4'hF, 32'h0, 1'b1);
    exp_data(32'h1014, 1'b0, 4'hF, 32'h0, 1'b1);
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h1000;
    k = 0; i_done = 1'b0; n = 0;
    while ((k < 6 || !i_done) && n < 200) begin
      @(negedge clk);
      n++;
      if (d_valid) begin
        k++;
        if (k == 6) d_req = 1'b0;
        else d_addr = 32'h1000 + 32'(4 * k);
      end
      if (i_valid) begin
        i_done = 1'b1;
        i_req  = 1'b0;
      end
    end
    chk("s5_d_done", 128'(k), 128'(6));
    chk("s5_i_done", 128'(i_done), 128'(1));
    chk("s5_order_drained", 128'(mem_exp_q.size()), 128'(0));

    // Spurious ack while idle
    @(negedge clk);
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("s6_busy", 128'(busy), 128'(0));
      chk("s6_i_valid", 128'(i_valid), 128'(0));
      chk("s6_d_valid", 128'(d_valid), 128'(0));
    end
    spurious = 1'b0;
    @(negedge clk);
    chk("s6_d_rdata_kept", 128'(d_rdata), 128'(last_load));

    // Reset in the middle of a data transaction
    mem_wait = 6;
    exp_data(32'h500, 1'b0, 4'hF, 32'h0, 1'b0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
    repeat (2) @(negedge clk);
    chk("s7_serving", 128'(busy), 128'(1));
    d_req = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("s7_mem_req_drop", 128'(mem_req), 128'(0));
    chk("s7_busy_drop", 128'(busy), 128'(0));
    repeat (3) begin
      @(negedge clk);
      chk("s7_no_d_valid", 128'(d_valid), 128'(0));
    end
    chk("s7_d_rdata_clr", 128'(d_rdata), 128'(0));
    chk("s7_i_rdata_clr", 128'(i_rdata), 128'(0));
    last_load = 32'h0;
    reset = 1'b1;
    mem_wait = 1;
    exp_fetch(32'h600);
    i_req = 1'b1; i_addr = 32'h600;
    @(negedge clk);
    chk("s7_rearb", 128'(mem_req), 128'(1));
    wait_vld(1'b0, 20, n);
    i_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("end_mem_q", 128'(mem_exp_q.size()), 128'(0));
    chk("end_i_q", 128'(i_exp_q.size()), 128'(0));
    chk("end_d_q", 128'(d_exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, shall set the address width of all address ports.
REQ-002 Parameter DATA_W, default 32, shall set the data width; byte-enable width is DATA_W/8.
REQ-003 Parameter MAX_DSTREAK, default 4, shall set the consecutive data grants allowed while a fetch waits.
REQ-004 clk  in  1  shall be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  shall be the asynchronous, active-low reset.
REQ-006 i_req  in  1  shall be the fetch request; i_addr  in  ADDR_W  shall be the fetch address.
REQ-007 i_rdata  out  DATA_W  shall be fetched data; i_valid  out  1  shall be the one-cycle completion pulse.
REQ-008 d_req  in  1  shall be the data request; d_we  in  1  shall be write; d_be  in  DATA_W/8  shall be byte enables.
REQ-009 d_addr  in  ADDR_W  and d_wdata  in  DATA_W  shall be the data address and write data.
REQ-010 d_rdata  out  DATA_W  shall be load data; d_valid  out  1  shall be the one-cycle completion pulse.
REQ-011 mem_req, mem_we  out  1; mem_be  out  DATA_W/8; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  shall drive the shared port.
REQ-012 mem_rdata  in  DATA_W  and mem_ack  in  1  shall return memory data and completion.
REQ-013 busy  out  1  shall be high whenever the state is not IDLE.

Function
REQ-014 FSM states shall be IDLE, SERVE_I and SERVE_D.
REQ-015 In IDLE, a pending request shall be granted; the next state becomes SERVE_I or SERVE_D.
REQ-016 On grant, address, we, be and wdata shall be captured into holding registers; the mem_* outputs shall be driven only from these registers.
REQ-017 Fetch grants shall force mem_we=0 and mem_be=all ones.
REQ-018 mem_req shall be high exactly in SERVE_I/SERVE_D; a request sampled at edge t shall produce mem_req=1 from cycle t+1.
REQ-019 mem_* outputs shall hold stable while mem_req=1 and mem_ack=0.
REQ-020 When mem_ack=1 in SERVE_x, the next edge shall load x_rdata from mem_rdata, pulse x_valid for one cycle and return to IDLE.
REQ-021 For data writes, d_rdata shall keep its previous value; d_valid shall still pulse.
REQ-022 Priority: data over fetch, except that a fetch shall win when i_req=1 and dstreak==MAX_DSTREAK.
REQ-023 dstreak shall increment on each data grant made while i_req=1, saturate at MAX_DSTREAK, and clear on any fetch grant.
REQ-024 In the cycle x_valid=1, requester x shall be masked from arbitration so a held req is not served twice.
REQ-025 mem_ack outside SERVE_I/SERVE_D shall be ignored.
REQ-026 Minimum turnaround shall be one IDLE cycle between transactions; with zero-wait memory (ack in the first SERVE cycle), completion latency shall be 2 cycles from request sample.

Reset
REQ-027 While reset=0, the FSM shall be IDLE, dstreak 0, and all outputs 0, including i_rdata, d_rdata and the holding registers.
REQ-028 Assertion mid-transaction shall drop mem_req immediately and abandon the transaction without any valid pulse.
REQ-029 On the first edge after deassertion, the FSM shall arbitrate normally.

Structure
REQ-030 State enum and default widths shall live in shared package mem_arb_pkg.
REQ-031 Grant selection (masking, priority and streak override) shall be one combinational sub-module, mem_arb_pick.

Verification
REQ-032 Lone fetch: i_req=1 with i_addr=0x100, ack after 3 cycles with rdata=0x00500093 -> mem_addr=0x100, mem_we=0, i_rdata=0x00500093, one i_valid pulse.
REQ-033 Simultaneous requests: i_req=d_req=1, d_we=1, d_addr=0x2000, d_be=0x3 -> data served first with mem_be=0x3, then the fetch; d_rdata is unchanged.
REQ-034 Starvation: d_req held for 6 transactions with i_req=1 and MAX_DSTREAK=4 -> the fetch is granted after the 4th data grant.
REQ-035 Held request: d_req is kept high through d_valid -> exactly one memory transaction for that address.
REQ-036 Mid-reset: reset=0 while in SERVE_D -> mem_req=0 immediately, no d_valid pulse, IDLE after release.
REQ-037 Spurious ack: mem_ack=1 in IDLE -> no valid pulse and no state change.
